ahb_arbiter: RTL
================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum number of accepted beats (NONSEQ/SEQ with hready=1) one master may hold the bus while another master requests it.
REQ-002 Parameter DEF_MST, default 0: master index parked on the bus when no master requests it.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 hbusreq  input  3  per-master bus request; bit0 data-side CPU master, bit1 instruction-fetch master, bit2 debug/DMA master.
REQ-006 htrans  input  2  HTRANS of the currently address-phase-owning master, already muxed by the interconnect.
REQ-007 hready  input  1  global HREADY from the selected slave.
REQ-008 hgrant  output  3  registered one-hot grant, one bit per master.
REQ-009 hmaster  output  2  registered index of the address-phase owner; drives the address/control mux.
REQ-010 hmaster_data  output  2  registered index of the data-phase owner; drives the HWDATA mux.

Function
REQ-011 hgrant SHALL be one-hot in every cycle after reset; exactly one bit is always set.
REQ-012 FSM states SHALL be PARK (no request, DEF_MST granted) and OWNED (a requesting master granted).
REQ-013 Arbitration SHALL be evaluated only in cycles where hready=1; with hready=0 hgrant, hmaster, hmaster_data, the counter and the state SHALL hold.
REQ-014 PARK -> OWNED when any hbusreq bit is 1 and hready=1; the winner's grant bit SHALL be set at that same clock edge (one-cycle request-to-grant latency).
REQ-015 OWNED -> PARK when hready=1 and hbusreq is all zero; hgrant SHALL return to DEF_MST at that edge.
REQ-016 In OWNED, re-arbitration SHALL occur at an hready=1 edge when the owner's hbusreq bit is 0, or when the tenure counter equals HOLD_MAX and any other hbusreq bit is 1.
REQ-017 Re-arbitration SHALL NOT occur while htrans=SEQ (2'b11) is presented with hready=1, except on the owner dropping its request; a tenure expiry is deferred until htrans is IDLE or NONSEQ.
REQ-018 Tenure counter SHALL be 5 bits wide, SHALL clear on any grant change, SHALL increment on each hready=1 cycle with htrans[1]=1, and SHALL saturate at HOLD_MAX.
REQ-019 hmaster SHALL load the index of the granted master at each hready=1 edge, i.e. it trails hgrant by one accepted cycle.
REQ-020 hmaster_data SHALL load the current hmaster at each hready=1 edge.
REQ-021 If the owner keeps requesting and no other master requests, the grant SHALL remain with the owner indefinitely regardless of the counter.
REQ-022 Simultaneous requests SHALL be resolved by the priority scheme of REQ-026/REQ-027 in a single cycle.

Reset
REQ-023 While rst_n=0: state=PARK, hgrant=one-hot(DEF_MST), hmaster=DEF_MST, hmaster_data=DEF_MST, tenure counter=0, round-robin pointer=0.
REQ-024 Reset asserted mid-transfer SHALL force the reset values immediately, without waiting for hready.
REQ-025 First arbitration after reset deassertion SHALL occur at the first hready=1 rising edge.

Configuration
REQ-026 With macro AHB_ARB_RR_EN defined: rotating priority; the search starts at the master after the last granted master (pointer updated on each grant change), so a master waits at most two tenures.
REQ-027 Without AHB_ARB_RR_EN: fixed priority master0 > master1 > master2; tenure expiry still hands off to the highest-priority other requester.

Verification
REQ-028 Reset, hbusreq=000, hready=1 for 5 cycles -> hgrant=001, hmaster=0, hmaster_data=0 throughout.
REQ-029 hbusreq=010 at cycle N, hready=1 -> hgrant=010 after edge N, hmaster=1 after edge N+1, hmaster_data=1 after edge N+2.
REQ-030 Owner 1 granted, hbusreq 010->000 while hready=0 for 3 cycles -> hgrant stays 010 until the first hready=1 edge, then 001 (PARK).
REQ-031 Fixed priority, hbusreq=111 held, htrans=NONSEQ, hready=1 -> master0 granted; after 16 beats hgrant=010; master2 granted only once masters 0 and 1 drop their requests.
REQ-032 AHB_ARB_RR_EN, hbusreq=111 held, NONSEQ beats -> grant sequence 001,010,100,001 with 16 beats per tenure.
REQ-033 Tenure expiry during htrans=SEQ burst -> grant unchanged until first IDLE/NONSEQ cycle with hready=1, then handed off; rst_n pulse mid-burst -> hgrant=001 asynchronously.

Source files
------------

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
//
// Purpose:
//   Three-master AHB bus arbiter. It grants the address bus to one requesting
//   master, parks on DEF_MST when nobody requests, and limits how long a
//   master may keep the bus while another master waits. Once the tenure
//   counter reaches HOLD_MAX, ownership is handed to another requester, but
//   never in the middle of a SEQ burst beat.
//
// Configuration:
//   AHB_ARB_RR_EN  defined   : rotating priority. The search starts at the
//                              master after the last winner.
//                  undefined : fixed priority master0 > master1 > master2.
//
// Parameters:
//   HOLD_MAX  number of accepted beats one master may hold the bus while
//             another master requests it (the tenure counter is 5 bits wide).
//   DEF_MST   index of the master parked on the bus when nobody requests it.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   rst_n          asynchronous, active-low reset
//   hbusreq_i[2:0] per-master request (0 data CPU, 1 ifetch, 2 debug/DMA)
//   htrans_i[1:0]  HTRANS of the current address-phase owner
//   hready_i       global HREADY
//   hgrant_o[2:0]  registered one-hot grant
//   hmaster_o      registered address-phase owner index
//   hmaster_data_o registered data-phase owner index
// -----------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int DEF_MST  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hbusreq_i,
    input  logic [1:0] htrans_i,
    input  logic       hready_i,
    output logic [2:0] hgrant_o,
    output logic [1:0] hmaster_o,
    output logic [1:0] hmaster_data_o
);

    localparam logic [4:0] HOLD_MAX_C = 5'(HOLD_MAX);
    localparam logic [1:0] DEF_IDX    = 2'(DEF_MST);
    localparam logic [2:0] DEF_GNT    = 3'(1 << DEF_MST);
    localparam logic [1:0] HTRANS_SEQ = 2'b11;

    typedef enum logic {
        PARK,
        OWNED
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] hm_q, hm_d;
    logic [1:0] hmd_q, hmd_d;
    logic [4:0] cnt_q, cnt_d;

`ifdef AHB_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
`endif

    logic [1:0] owner_idx;
    logic [2:0] others;
    logic       owner_drop;
    logic       expired;
    logic [2:0] cand;
    logic [1:0] win;

    // Index of the current grant holder (gnt_q is always one-hot).
    always_comb begin
        owner_idx = 2'd0;
        if (gnt_q[2]) begin
            owner_idx = 2'd2;
        end else if (gnt_q[1]) begin
            owner_idx = 2'd1;
        end
    end

    assign others     = hbusreq_i & ~gnt_q;
    assign owner_drop = ~|(hbusreq_i & gnt_q);
    // A tenure expiry may only act on a beat that does not continue a burst.
    assign expired    = (cnt_q == HOLD_MAX_C) && (|others) && (htrans_i != HTRANS_SEQ);

    // When the bus is parked, or the owner has let go, every requester
    // competes. A tenure expiry excludes the current owner.
    assign cand = ((state_q == PARK) || owner_drop) ? hbusreq_i : others;

    // Select the winner among the candidate masters.
`ifdef AHB_ARB_RR_EN
    always_comb begin
        logic found;
        int   idx;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = int'(ptr_q) + k;
            if (idx > 2) begin
                idx = idx - 3;
            end
            if (!found && cand[idx]) begin
                win   = 2'(idx);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win = 2'd2;
        if (cand[0]) begin
            win = 2'd0;
        end else if (cand[1]) begin
            win = 2'd1;
        end
    end
`endif

    // Next-state and output logic. Nothing moves while hready_i is low.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hm_d    = hm_q;
        hmd_d   = hmd_q;
        cnt_d   = cnt_q;
`ifdef AHB_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (hready_i) begin
            // The address and data owners trail the grant by one and two
            // accepted cycles.
            hm_d  = owner_idx;
            hmd_d = hm_q;
            case (state_q)
                PARK: begin
                    cnt_d = 5'd0;
                    if (|hbusreq_i) begin
                        state_d = OWNED;
                        gnt_d   = 3'(1 << win);
`ifdef AHB_ARB_RR_EN
                        ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
                    end
                end
                OWNED: begin
                    if (hbusreq_i == 3'b000) begin
                        state_d = PARK;
                        gnt_d   = DEF_GNT;
                        cnt_d   = 5'd0;
                    end else if (owner_drop || expired) begin
                        gnt_d   = 3'(1 << win);
                        cnt_d   = 5'd0;
`ifdef AHB_ARB_RR_EN
                        ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
                    end else if (htrans_i[1] && (cnt_q != HOLD_MAX_C)) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = PARK;
                    gnt_d   = DEF_GNT;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PARK;
            gnt_q   <= DEF_GNT;
            hm_q    <= DEF_IDX;
            hmd_q   <= DEF_IDX;
            cnt_q   <= 5'd0;
`ifdef AHB_ARB_RR_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hm_q    <= hm_d;
            hmd_q   <= hmd_d;
            cnt_q   <= cnt_d;
`ifdef AHB_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign hgrant_o       = gnt_q;
    assign hmaster_o      = hm_q;
    assign hmaster_data_o = hmd_q;

endmodule
